spi_sync_ram: RTL and testbench

//   Single-port synchronous RAM stage directly downstream of the SPI slave.

---
 rtl/spi_sync_ram.sv | 83 ++++++++
 tb/tb_spi_sync_ram.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/spi_sync_ram.sv
// Single-port synchronous RAM behind the SPI slave: decodes framed 2-bit command + payload words.
// Optional RAM_AUTO_INC_EN: post-increment write/read addresses for streamed transfers.
module spi_sync_ram #(
  parameter int MEM_DEPTH = 256,
  parameter int ADDR_SIZE = 8,
  parameter int WORD_SIZE = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [ADDR_SIZE+1:0]   rx_data,
  input  logic                   rx_valid,
  output logic [WORD_SIZE-1:0]   tx_data,
  output logic                   tx_valid,
  output logic                   address_received,
  output logic                   cmd_err
);

  typedef enum logic [1:0] {
    CMD_WR_ADDR = 2'b00,
    CMD_WR_DATA = 2'b01,
    CMD_RD_ADDR = 2'b10,
    CMD_RD_DATA = 2'b11
  } cmd_e;

  logic [WORD_SIZE-1:0] mem [MEM_DEPTH];
  logic [ADDR_SIZE-1:0] wr_addr;
  logic [ADDR_SIZE-1:0] rd_addr;
  logic [ADDR_SIZE-1:0] payload;
  cmd_e                 cmd;

  assign cmd     = cmd_e'(rx_data[ADDR_SIZE+1:ADDR_SIZE]);
  assign payload = rx_data[ADDR_SIZE-1:0];

  // Storage is deliberately left out of reset so contents survive an rst_n pulse.
  always_ff @(posedge clk) begin
    if (rx_valid && cmd == CMD_WR_DATA)
      mem[wr_addr] <= WORD_SIZE'(payload);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_addr          <= '0;
      rd_addr          <= '0;
      tx_data          <= '0;
      tx_valid         <= 1'b0;
      address_received <= 1'b0;
      cmd_err          <= 1'b0;
    end else begin
      tx_valid <= 1'b0;
      cmd_err  <= 1'b0;
      if (rx_valid) begin
        unique case (cmd)
          CMD_WR_ADDR: wr_addr <= payload;
          CMD_WR_DATA: begin
`ifdef RAM_AUTO_INC_EN
            wr_addr <= wr_addr + ADDR_SIZE'(1);
`endif
          end
          CMD_RD_ADDR: begin
            rd_addr          <= payload;
            address_received <= 1'b1;
          end
          CMD_RD_DATA: begin
            if (address_received) begin
              tx_data  <= mem[rd_addr];
              tx_valid <= 1'b1;
`ifdef RAM_AUTO_INC_EN
              // Flag stays set so the master can stream reads without a new RD_ADDR.
              rd_addr  <= rd_addr + ADDR_SIZE'(1);
`else
              address_received <= 1'b0;
`endif
            end else begin
              cmd_err <= 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_spi_sync_ram.sv
// Directed bench for spi_sync_ram; expectations follow the build's RAM_AUTO_INC_EN setting.
module tb_spi_sync_ram;

`ifdef RAM_AUTO_INC_EN
  localparam logic AUTO_INC = 1'b1;
`else
  localparam logic AUTO_INC = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic [9:0] rx_data;
  logic       rx_valid;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       address_received;
  logic       cmd_err;

  int checks = 0;
  int errors = 0;

  spi_sync_ram #(.MEM_DEPTH(256), .ADDR_SIZE(8), .WORD_SIZE(8)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .rx_data          (rx_data),
    .rx_valid         (rx_valid),
    .tx_data          (tx_data),
    .tx_valid         (tx_valid),
    .address_received (address_received),
    .cmd_err          (cmd_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Present one command for a single rising edge, return 1 time unit after it.
  task automatic send(input logic [9:0] d);
    rx_data  = d;
    rx_valid = 1'b1;
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
  endtask

  task automatic idle(input logic [9:0] d);
    rx_data  = d;
    rx_valid = 1'b0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n    = 1'b0;
    rx_valid = 1'b0;
    rx_data  = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_tx_data", tx_data, 8'h00);
    chk("rst_tx_valid", {7'd0, tx_valid}, 8'h00);
    chk("rst_addr_rcvd", {7'd0, address_received}, 8'h00);
    chk("rst_cmd_err", {7'd0, cmd_err}, 8'h00);
    rst_n = 1'b1;
    idle(10'h000);

    // Basic write then read
    send(10'h012);
    send(10'h1A5);
    send(10'h212);
    chk("rdaddr_flag", {7'd0, address_received}, 8'h01);
    send(10'h300);
    chk("rd_data_a5", tx_data, 8'hA5);
    chk("rd_valid", {7'd0, tx_valid}, 8'h01);
    chk("rd_flag_after", {7'd0, address_received}, {7'd0, AUTO_INC});
    idle(10'h000);
    chk("rd_valid_pulse", {7'd0, tx_valid}, 8'h00);
    chk("rd_data_hold", tx_data, 8'hA5);

    // Asynchronous reset in the middle of a read response
    send(10'h212);
    send(10'h300);
    chk("pre_rst_valid", {7'd0, tx_valid}, 8'h01);
    #1 rst_n = 1'b0;
    #1;
    chk("arst_tx_data", tx_data, 8'h00);
    chk("arst_tx_valid", {7'd0, tx_valid}, 8'h00);
    chk("arst_flag", {7'd0, address_received}, 8'h00);
    chk("arst_cmd_err", {7'd0, cmd_err}, 8'h00);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;
    send(10'h300);
    chk("post_rst_err", {7'd0, cmd_err}, 8'h01);
    chk("post_rst_valid", {7'd0, tx_valid}, 8'h00);
    chk("post_rst_data", tx_data, 8'h00);
    idle(10'h000);
    chk("err_pulse", {7'd0, cmd_err}, 8'h00);
    send(10'h212);
    send(10'h300);
    chk("mem_kept", tx_data, 8'hA5);

    // Read-after-write on consecutive cycles
    send(10'h040);
    send(10'h15C);
    send(10'h240);
    send(10'h300);
    chk("raw_data", tx_data, 8'h5C);
    chk("raw_valid", {7'd0, tx_valid}, 8'h01);

    // Inputs ignored while rx_valid is low
    idle(10'h1FF);
    idle(10'h2AA);
    chk("novld_flag", {7'd0, address_received}, {7'd0, AUTO_INC});
    chk("novld_data", tx_data, 8'h5C);
    chk("novld_err", {7'd0, cmd_err}, 8'h00);
    send(10'h240);
    send(10'h300);
    chk("novld_mem", tx_data, 8'h5C);

`ifndef RAM_AUTO_INC_EN
    // Read-data without address
    send(10'h3FF);
    chk("noaddr_err", {7'd0, cmd_err}, 8'h01);
    chk("noaddr_valid", {7'd0, tx_valid}, 8'h00);
    chk("noaddr_data", tx_data, 8'h5C);
    // wr_addr must still be 0x40; a second RD_ADDR overwrites the first
    send(10'h177);
    send(10'h212);
    send(10'h240);
    chk("dbl_flag", {7'd0, address_received}, 8'h01);
    send(10'h300);
    chk("noinc_data", tx_data, 8'h77);
    send(10'h300);
    chk("noinc_err", {7'd0, cmd_err}, 8'h01);
    chk("noinc_hold", tx_data, 8'h77);
`else
    // Streamed write and read across the address wrap
    send(10'h0FF);
    send(10'h111);
    send(10'h122);
    send(10'h2FF);
    send(10'h300);
    chk("inc_rd0", tx_data, 8'h11);
    chk("inc_flag0", {7'd0, address_received}, 8'h01);
    send(10'h300);
    chk("inc_rd1", tx_data, 8'h22);
    chk("inc_valid1", {7'd0, tx_valid}, 8'h01);
    chk("inc_flag1", {7'd0, address_received}, 8'h01);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout observed running expected finished");
    $fatal(1, "timeout");
  end

endmodule
